// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic, bit-serial shifts, Z80-layout flags.
// Define ALU_SEQ_ADC_SBC_EN to implement ADC/SBC (opcodes 13/14); otherwise they act as illegal.
module alu_seq #(
    parameter int         WIDTH       = 8,
    parameter logic [7:0] FLAGS_RESET = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_CP  = 4'd5,  OP_SLL = 4'd6,  OP_SRL = 4'd7;
    localparam logic [3:0] OP_SLA = 4'd8,  OP_SRA = 4'd9,  OP_ROR = 4'd10, OP_INC = 4'd11;
    localparam logic [3:0] OP_DEC = 4'd12, OP_ADC = 4'd13, OP_SBC = 4'd14;

    logic [1:0]       r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_val;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [7:0]       r_flags;

    logic             w_accept, w_is_shift, w_sub, w_cin, w_ovf, w_step_bit;
    logic [CW-1:0]    w_shcnt;
    logic [WIDTH-1:0] w_opb, w_res, w_step_val;
    logic [WIDTH:0]   w_sum;
    logic [4:0]       w_half;
    logic [7:0]       w_flg;

    function automatic logic [7:0] pk(input logic s, z, h, pv, n, c);
        return {s, z, 1'b0, h, 1'b0, pv, n, c};
    endfunction

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_result;
    assign flags     = r_flags;
    assign w_accept  = in_valid & in_ready;

    assign w_is_shift = (opcode == OP_SLL) | (opcode == OP_SRL) | (opcode == OP_SLA) |
                        (opcode == OP_SRA) | (opcode == OP_ROR);
    // Counts of WIDTH or more saturate to WIDTH, except ROR which wraps.
    assign w_shcnt = ((opcode != OP_ROR) && (|b[WIDTH-1:CW-1])) ? CW'(WIDTH) : {1'b0, b[CW-2:0]};

    assign w_sub = (opcode == OP_SUB) | (opcode == OP_CP) | (opcode == OP_DEC) | (opcode == OP_SBC);
    assign w_opb = ((opcode == OP_INC) | (opcode == OP_DEC)) ? WIDTH'(1) : b;
`ifdef ALU_SEQ_ADC_SBC_EN
    assign w_cin = ((opcode == OP_ADC) | (opcode == OP_SBC)) & r_flags[0];
`else
    assign w_cin = 1'b0;
`endif

    always_comb begin
        if (w_sub) begin
            w_sum  = {1'b0, a} - {1'b0, w_opb} - {{WIDTH{1'b0}}, w_cin};
            w_half = {1'b0, a[3:0]} - {1'b0, w_opb[3:0]} - {4'b0, w_cin};
            w_ovf  = (a[WIDTH-1] != w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            w_sum  = {1'b0, a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
            w_half = {1'b0, a[3:0]} + {1'b0, w_opb[3:0]} + {4'b0, w_cin};
            w_ovf  = (a[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end
    end

    // Result/flags for everything that completes in one cycle, including zero-count shifts.
    always_comb begin
        w_res = '0;
        w_flg = r_flags;
        case (opcode)
            OP_ADD, OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_flg = pk(w_sum[WIDTH-1], w_sum[WIDTH-1:0] == '0, w_half[4], w_ovf, w_sub, w_sum[WIDTH]);
            end
            OP_INC, OP_DEC: begin
                w_res = w_sum[WIDTH-1:0];
                w_flg = pk(w_sum[WIDTH-1], w_sum[WIDTH-1:0] == '0, w_half[4], w_ovf, w_sub, r_flags[0]);
            end
`ifdef ALU_SEQ_ADC_SBC_EN
            OP_ADC, OP_SBC: begin
                w_res = w_sum[WIDTH-1:0];
                w_flg = pk(w_sum[WIDTH-1], w_sum[WIDTH-1:0] == '0, w_half[4], w_ovf, w_sub, w_sum[WIDTH]);
            end
`endif
            OP_CP: begin
                w_res = a;
                w_flg = pk(a[WIDTH-1], w_sum[WIDTH-1:0] == '0, w_half[4], w_ovf, 1'b1, w_sum[WIDTH]);
            end
            OP_AND: begin
                w_res = a & b;
                w_flg = pk(w_res[WIDTH-1], w_res == '0, 1'b1, ~^w_res, 1'b0, 1'b0);
            end
            OP_OR, OP_XOR: begin
                w_res = (opcode == OP_OR) ? (a | b) : (a ^ b);
                w_flg = pk(w_res[WIDTH-1], w_res == '0, 1'b0, ~^w_res, 1'b0, 1'b0);
            end
            OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROR: begin
                w_res = a;
                w_flg = pk(a[WIDTH-1], a == '0, 1'b0, ~^a, 1'b0, 1'b0);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_step_bit = r_val[0];
        w_step_val = {1'b0, r_val[WIDTH-1:1]};
        case (r_op)
            OP_SLL, OP_SLA: begin
                w_step_bit = r_val[WIDTH-1];
                w_step_val = {r_val[WIDTH-2:0], 1'b0};
            end
            OP_SRA:  w_step_val = {r_val[WIDTH-1], r_val[WIDTH-1:1]};
            OP_ROR:  w_step_val = {r_val[0], r_val[WIDTH-1:1]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_val    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= FLAGS_RESET;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_val <= w_step_val;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_result <= w_step_val;
                        r_flags  <= pk(w_step_val[WIDTH-1], w_step_val == '0, 1'b0, ~^w_step_val,
                                       1'b0, w_step_bit);
                        r_state  <= DONE;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_op <= opcode;
                        if (w_is_shift && (w_shcnt != '0)) begin
                            r_val   <= a;
                            r_cnt   <= w_shcnt;
                            r_state <= SHIFT;
                        end else begin
                            r_result <= w_res;
                            r_flags  <= w_flg;
                            r_state  <= DONE;
                        end
                    end else if ((r_state == DONE) && out_ready) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
